// File: rtl/mips_boot_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_boot_pkg
//  Description : Shared types and constants for the IMEM boot loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_boot_pkg;

   // Loader states, one per phase of the image stream
   typedef enum logic [2:0] {
      LEN_HI = 3'd0,
      LEN_LO = 3'd1,
      DATA   = 3'd2,
      WRITE  = 3'd3,
      DONE   = 3'd4,
      ERR    = 3'd5
   } boot_state_t;

   localparam int LEN_W          = 16;
   localparam int BYTES_PER_WORD = 4;
   localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

   // The host link may only hand over a byte while a header or data byte is expected
   function automatic logic acceptsByte(input boot_state_t s);
      return (s == LEN_HI) || (s == LEN_LO) || (s == DATA);
   endfunction

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Shifts bytes MSB-first into a 32-bit word and flags the
//                transfer that completes the word.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
   import mips_boot_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        shiftEn,
   input  logic [7:0]  byteIn,
   output logic [31:0] word,
   output logic        wordFull
);

   localparam logic [BYTE_IDX_W-1:0] c_LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

   logic [31:0]           r_word;
   logic [BYTE_IDX_W-1:0] r_byteIdx;

   // Shift register and byte counter; the counter wraps to 0 after the last byte
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_word    <= '0;
         r_byteIdx <= '0;
      end else if (shiftEn) begin
         r_word    <= {r_word[23:0], byteIn};
         r_byteIdx <= r_byteIdx + 1'b1;
      end
   end

   assign word     = r_word;
   assign wordFull = shiftEn && (r_byteIdx == c_LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_loader
//  Description : Streams a length-prefixed big-endian program image from a
//                byte link into IMEM and holds the core in reset until the
//                whole image has been written.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_loader
   import mips_boot_pkg::*;
#(
   parameter int ADDR_W = 6
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        byte_in,
   input  logic              byteValid_in,
   output logic              byteReady_out,
   input  logic              reload_in,
   output logic              imemWrite_out,
   output logic [31:0]       imemAddr_out,
   output logic [31:0]       imemData_out,
   output logic              coreReset_out,
   output logic              done_out,
   output logic              error_out,
   output logic [LEN_W-1:0]  wordCount_out
);

   // Capacity in words, one bit wider than the header so 2**16 cannot alias
   localparam logic [LEN_W:0] c_CAPACITY = {{LEN_W{1'b0}}, 1'b1} << ADDR_W;

   boot_state_t        r_state;
   boot_state_t        w_stateNext;
   logic [7:0]         r_lenHi;
   logic [LEN_W-1:0]   r_wordTotal;
   logic [ADDR_W-1:0]  r_wordIdx;
   logic [LEN_W-1:0]   r_wordCount;

   logic               w_xfer;
   logic               w_reload;
   logic               w_shiftEn;
   logic               w_wordFull;
   logic [31:0]        w_packedWord;
   logic [LEN_W-1:0]   w_lenFull;
   logic               w_lenTooBig;
   logic               w_lastWord;

   assign byteReady_out = acceptsByte(r_state);
   assign w_xfer        = byteValid_in && byteReady_out;
   assign w_reload      = reload_in && ((r_state == DONE) || (r_state == ERR));
   assign w_shiftEn     = w_xfer && (r_state == DATA);

   // Full header word as it will be once the low byte on the link is taken
   assign w_lenFull     = {r_lenHi, byte_in};
   assign w_lenTooBig   = {1'b0, w_lenFull} > c_CAPACITY;
   assign w_lastWord    = (r_wordCount + LEN_W'(1)) == r_wordTotal;

   byte_packer u_packer (
      .clk      (clk),
      .reset    (reset),
      .clear    (w_reload),
      .shiftEn  (w_shiftEn),
      .byteIn   (byte_in),
      .word     (w_packedWord),
      .wordFull (w_wordFull)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= LEN_HI;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state decode
   always_comb begin
      w_stateNext = r_state;
      unique case (r_state)
         LEN_HI: begin
            if (w_xfer) w_stateNext = LEN_LO;
         end
         LEN_LO: begin
            if (w_xfer) begin
               if (w_lenFull == '0)   w_stateNext = DONE;
               else if (w_lenTooBig)  w_stateNext = ERR;
               else                   w_stateNext = DATA;
            end
         end
         DATA: begin
            if (w_wordFull) w_stateNext = WRITE;
         end
         WRITE: begin
            w_stateNext = w_lastWord ? DONE : DATA;
         end
         DONE, ERR: begin
            if (reload_in) w_stateNext = LEN_HI;
         end
         default: begin
            w_stateNext = LEN_HI;
         end
      endcase
   end

   // Header capture; N is cleared when a reload restarts the stream
   always_ff @(posedge clk) begin
      if (reset || w_reload) begin
         r_lenHi     <= '0;
         r_wordTotal <= '0;
      end else if (w_xfer && (r_state == LEN_HI)) begin
         r_lenHi     <= byte_in;
      end else if (w_xfer && (r_state == LEN_LO)) begin
         r_wordTotal <= w_lenFull;
      end
   end

   // Word index and written-word count advance once per write strobe
   always_ff @(posedge clk) begin
      if (reset || w_reload) begin
         r_wordIdx   <= '0;
         r_wordCount <= '0;
      end else if (r_state == WRITE) begin
         r_wordIdx   <= r_wordIdx + 1'b1;
         r_wordCount <= r_wordCount + LEN_W'(1);
      end
   end

   // Write port is quiet (all zero) outside the single write cycle
   assign imemWrite_out = (r_state == WRITE);
   assign imemAddr_out  = (r_state == WRITE) ? {{(30 - ADDR_W){1'b0}}, r_wordIdx, 2'b00} : '0;
   assign imemData_out  = (r_state == WRITE) ? w_packedWord : '0;

   assign coreReset_out = (r_state != DONE);
   assign done_out      = (r_state == DONE);
   assign error_out     = (r_state == ERR);
   assign wordCount_out = r_wordCount;

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot_loader
//  Description : Self-checking bench for imem_boot_loader: directed table of
//                images, hand-written corner sequences, randomized images
//                checked against an image-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

   localparam int ADDR_W = 6;
   localparam int CAP    = 1 << ADDR_W;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  byte_in = '0;
   logic        byteValid_in = 1'b0;
   logic        reload_in = 1'b0;
   logic        byteReady_out;
   logic        imemWrite_out;
   logic [31:0] imemAddr_out;
   logic [31:0] imemData_out;
   logic        coreReset_out;
   logic        done_out;
   logic        error_out;
   logic [15:0] wordCount_out;

   imem_boot_loader #(.ADDR_W(ADDR_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .byte_in       (byte_in),
      .byteValid_in  (byteValid_in),
      .byteReady_out (byteReady_out),
      .reload_in     (reload_in),
      .imemWrite_out (imemWrite_out),
      .imemAddr_out  (imemAddr_out),
      .imemData_out  (imemData_out),
      .coreReset_out (coreReset_out),
      .done_out      (done_out),
      .error_out     (error_out),
      .wordCount_out (wordCount_out)
   );

   always #5 clk = ~clk;

   int nCompared = 0;
   int nFailed   = 0;
   logic [31:0] gotAddr[$];
   logic [31:0] gotData[$];

   typedef struct {
      logic [15:0] n;
      int          mode;
      logic [31:0] w0;
      logic [31:0] w1;
      logic        expDone;
      logic        expErr;
      int          expStrobes;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nFailed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Record every write strobe; a strobe must never coincide with an open link or a released core
   always @(negedge clk) begin
      if (imemWrite_out === 1'b1) begin
         gotAddr.push_back(imemAddr_out);
         gotData.push_back(imemData_out);
         check("strobe_ready_low", {31'b0, byteReady_out}, 32'd0);
         check("strobe_core_held", {31'b0, coreReset_out}, 32'd1);
      end
   end

   task automatic checkResetValues(input string tag);
      check({tag, "_write"},  {31'b0, imemWrite_out}, 32'd0);
      check({tag, "_addr"},   imemAddr_out, 32'd0);
      check({tag, "_data"},   imemData_out, 32'd0);
      check({tag, "_coreRst"},{31'b0, coreReset_out}, 32'd1);
      check({tag, "_done"},   {31'b0, done_out}, 32'd0);
      check({tag, "_err"},    {31'b0, error_out}, 32'd0);
      check({tag, "_count"},  {16'b0, wordCount_out}, 32'd0);
      check({tag, "_ready"},  {31'b0, byteReady_out}, 32'd1);
   endtask

   // Offer one byte until it is taken, then drop valid
   task automatic sendByte(input logic [7:0] b);
      logic xfer;
      byte_in      = b;
      byteValid_in = 1'b1;
      for (int i = 0; i < 50; i++) begin
         xfer = byteReady_out;
         step();
         if (xfer) begin
            byteValid_in = 1'b0;
            return;
         end
      end
      byteValid_in = 1'b0;
      check("sendByte_timeout", 32'd0, 32'd1);
   endtask

   task automatic doReload(input string tag);
      reload_in = 1'b1;
      step();
      reload_in = 1'b0;
      check({tag, "_reload_coreRst"}, {31'b0, coreReset_out}, 32'd1);
      check({tag, "_reload_count"},   {16'b0, wordCount_out}, 32'd0);
      check({tag, "_reload_done"},    {31'b0, done_out}, 32'd0);
      check({tag, "_reload_err"},     {31'b0, error_out}, 32'd0);
   endtask

   // Stream one image; the reference model derives the expected write list
   // and final status straight from the image format.
   task automatic runImage(input logic [15:0] n, input logic [31:0] words[$], input int mode,
                           input string tag, output logic gotDone, output logic gotErr,
                           output int gotStrobes);
      logic [7:0]  stream[$];
      logic        expErr;
      int          expWords;
      int          idx;
      int          cyc;
      logic        want;
      logic        xfer;
      expErr   = (n > CAP);
      expWords = expErr ? 0 : int'(n);
      stream.push_back(n[15:8]);
      stream.push_back(n[7:0]);
      for (int k = 0; k < expWords; k++) begin
         stream.push_back(words[k][31:24]);
         stream.push_back(words[k][23:16]);
         stream.push_back(words[k][15:8]);
         stream.push_back(words[k][7:0]);
      end
      gotAddr.delete();
      gotData.delete();
      idx = 0;
      cyc = 0;
      while (idx < stream.size() && cyc < 3000) begin
         case (mode)
            0:       want = 1'b1;
            1:       want = cyc[0];
            default: want = 1'($urandom_range(0, 1));
         endcase
         byte_in      = stream[idx];
         byteValid_in = want;
         xfer         = want && byteReady_out;
         step();
         if (xfer) idx++;
         cyc++;
      end
      byteValid_in = 1'b0;
      if (idx != stream.size()) check({tag, "_feed_timeout"}, 32'(idx), 32'(stream.size()));
      for (int i = 0; i < 40 && !(done_out || error_out); i++) step();
      gotDone    = done_out;
      gotErr     = error_out;
      gotStrobes = gotAddr.size();
      check({tag, "_strobes"}, 32'(gotStrobes), 32'(expWords));
      check({tag, "_coreRst"}, {31'b0, coreReset_out}, {31'b0, expErr});
      check({tag, "_count"},   {16'b0, wordCount_out}, 32'(expWords));
      for (int k = 0; k < gotStrobes && k < expWords; k++) begin
         check($sformatf("%s_addr%0d", tag, k), gotAddr[k], 32'(4 * k));
         check($sformatf("%s_data%0d", tag, k), gotData[k], words[k]);
      end
   endtask

   initial begin
      logic [31:0] words[$];
      logic        gDone;
      logic        gErr;
      int          gStrobes;
      logic [15:0] n;
      int          sel;
      int          mode;

      // Reset state
      reset = 1'b1;
      step();
      step();
      checkResetValues("reset");
      reset = 1'b0;

      // Directed image table
      vecs[0] = '{16'd2,      0, 32'h2008_0005, 32'h0000_0008, 1'b1, 1'b0, 2};
      vecs[1] = '{16'd1,      1, 32'h2008_0005, 32'h0000_0000, 1'b1, 1'b0, 1};
      vecs[2] = '{16'd0,      0, 32'h0,         32'h0,         1'b1, 1'b0, 0};
      vecs[3] = '{16'd65,     0, 32'h0,         32'h0,         1'b0, 1'b1, 0};
      vecs[4] = '{16'd1,      2, $urandom(),    32'h0,         1'b1, 1'b0, 1};
      vecs[5] = '{16'd64,     0, $urandom(),    $urandom(),    1'b1, 1'b0, 64};
      vecs[6] = '{16'h0100,   1, 32'h0,         32'h0,         1'b0, 1'b1, 0};
      vecs[7] = '{16'hFFFF,   0, 32'h0,         32'h0,         1'b0, 1'b1, 0};

      for (int v = 0; v < 8; v++) begin
         words.delete();
         words.push_back(vecs[v].w0);
         words.push_back(vecs[v].w1);
         for (int k = 2; k < CAP; k++) words.push_back($urandom());
         runImage(vecs[v].n, words, vecs[v].mode, $sformatf("vec%0d", v), gDone, gErr, gStrobes);
         check($sformatf("vec%0d_done", v),     {31'b0, gDone}, {31'b0, vecs[v].expDone});
         check($sformatf("vec%0d_err", v),      {31'b0, gErr},  {31'b0, vecs[v].expErr});
         check($sformatf("vec%0d_nstrobe", v),  32'(gStrobes),  32'(vecs[v].expStrobes));
         doReload($sformatf("vec%0d", v));
      end

      // reload in DATA is ignored; write strobe follows the 4th byte by one cycle
      gotAddr.delete();
      gotData.delete();
      sendByte(8'h00);
      sendByte(8'h01);
      sendByte(8'hAB);
      sendByte(8'hCD);
      reload_in = 1'b1;
      step();
      reload_in = 1'b0;
      check("ignreload_ready",   {31'b0, byteReady_out}, 32'd1);
      check("ignreload_coreRst", {31'b0, coreReset_out}, 32'd1);
      sendByte(8'h12);
      sendByte(8'h34);
      check("lat_write",   {31'b0, imemWrite_out}, 32'd1);
      check("lat_addr",    imemAddr_out, 32'd0);
      check("lat_data",    imemData_out, 32'hABCD_1234);
      check("lat_ready",   {31'b0, byteReady_out}, 32'd0);
      step();
      check("lat_done",    {31'b0, done_out}, 32'd1);
      check("lat_coreRst", {31'b0, coreReset_out}, 32'd0);
      check("lat_write0",  {31'b0, imemWrite_out}, 32'd0);
      check("lat_count",   {16'b0, wordCount_out}, 32'd1);
      doReload("lat");

      // Reset in the middle of word 1 aborts the load
      sendByte(8'h00);
      sendByte(8'h02);
      sendByte(8'h11);
      sendByte(8'h22);
      sendByte(8'h33);
      sendByte(8'h44);
      sendByte(8'h55);
      sendByte(8'h66);
      check("premid_count", {16'b0, wordCount_out}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      checkResetValues("midreset");
      words.delete();
      words.push_back(32'h0BAD_F00D);
      runImage(16'd1, words, 0, "postreset", gDone, gErr, gStrobes);
      check("postreset_done", {31'b0, gDone}, 32'd1);
      doReload("postreset");

      // Randomized images against the model
      for (int r = 0; r < 10; r++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0:       n = 16'd0;
            1:       n = 16'(CAP);
            2:       n = 16'(CAP + 1);
            3:       n = 16'($urandom_range(CAP + 1, 65535));
            default: n = 16'($urandom_range(1, 12));
         endcase
         mode = $urandom_range(0, 2);
         words.delete();
         for (int k = 0; k < CAP; k++) words.push_back($urandom());
         runImage(n, words, mode, $sformatf("rnd%0d", r), gDone, gErr, gStrobes);
         check($sformatf("rnd%0d_done", r), {31'b0, gDone}, {31'b0, (n <= CAP)});
         check($sformatf("rnd%0d_err", r),  {31'b0, gErr},  {31'b0, (n > CAP)});
         doReload($sformatf("rnd%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
      $finish;
   end

endmodule
`default_nettype wire
